// File: rtl/m_alu_normalizer.sv
// Multi-cycle leading-bit normalizer for the ALU: shifts the operand left until its
// most significant significant bit reaches the top and reports a preshifter descriptor that undoes the shift.
package alu_shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_SHL = 2'd0,
    SHIFT_SHR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_type_e;

  typedef struct packed {
    shift_type_e shift_type;
    logic [4:0]  amount;
  } s_shift;
endpackage

module m_alu_normalizer
  import alu_shift_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_amount,
  output s_shift      out_shift,
  output logic        out_zero
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e      r_state;
  logic [31:0] r_work;
  logic        r_mode;
  logic [4:0]  r_count;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_amount;
  logic        r_out_zero;
  shift_type_e r_out_type;

  logic [STEP-1:0] w_win;
  logic            w_ref;
  logic            w_run;
  logic [4:0]      w_k;
  logic [31:0]     w_work_nxt;
  logic [4:0]      w_count_nxt;
  logic            w_zero_in;

  // Signed mode looks one bit lower: bit 31 is the sign itself and is never shifted out.
  always_comb begin
    w_win = r_mode ? r_work[30 -: STEP] : r_work[31 -: STEP];
    w_ref = r_mode & r_work[31];
    w_run = 1'b1;
    w_k   = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (w_run && (w_win[STEP-1] == w_ref)) begin
        w_k = w_k + 5'd1;
      end else begin
        w_run = 1'b0;
      end
      w_win = w_win << 1;
    end
    w_work_nxt  = r_work << w_k;
    w_count_nxt = r_count + w_k;
  end

  assign w_zero_in = (in_data == '0) || (in_signed && (in_data == '1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_work       <= '0;
      r_mode       <= 1'b0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_amount <= '0;
      r_out_zero   <= 1'b0;
      r_out_type   <= SHIFT_SHR;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_mode  <= in_signed;
            r_count <= '0;
            if (w_zero_in) begin
              r_out_data   <= in_data;
              r_out_amount <= '0;
              r_out_zero   <= 1'b1;
              r_out_type   <= in_signed ? SHIFT_ASR : SHIFT_SHR;
              r_state      <= DONE;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          r_work  <= w_work_nxt;
          r_count <= w_count_nxt;
          if ({27'd0, w_k} < STEP) begin
            r_out_data   <= w_work_nxt;
            r_out_amount <= w_count_nxt;
            r_out_zero   <= 1'b0;
            r_out_type   <= r_mode ? SHIFT_ASR : SHIFT_SHR;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready             = (r_state == IDLE);
  assign out_valid            = (r_state == DONE);
  assign out_data             = r_out_data;
  assign out_amount           = r_out_amount;
  assign out_zero             = r_out_zero;
  assign out_shift.shift_type = r_out_type;
  assign out_shift.amount     = r_out_amount;

endmodule

// File: tb/tb_m_alu_normalizer.sv
// Self-checking bench for m_alu_normalizer: three instances (STEP 1, 4, 16) checked against
// a count-leading-bits reference model, the preshifter round trip and the latency formula.
module tb_m_alu_normalizer;
  import alu_shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [2:0]  in_signed = '0;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = '0;
  logic [2:0]  out_zero;
  logic [31:0] in_data    [3];
  logic [31:0] out_data   [3];
  logic [4:0]  out_amount [3];
  s_shift      out_shift  [3];

  int n_total = 0;
  int n_bad   = 0;

  function automatic int step_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 4 : 16);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    m_alu_normalizer #(.STEP((g == 0) ? 1 : ((g == 1) ? 4 : 16))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_signed (in_signed[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_amount(out_amount[g]),
      .out_shift (out_shift[g]),
      .out_zero  (out_zero[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: shift amount is the count of leading zeros (unsigned) or redundant sign bits (signed).
  task automatic ref_norm(input logic [31:0] x, input logic sg, output int a, output logic zero);
    logic [31:0] y;
    int lz;
    zero = sg ? ((x == 32'h0) || (x == 32'hFFFF_FFFF)) : (x == 32'h0);
    a = 0;
    if (!zero) begin
      y  = (sg && x[31]) ? ~x : x;
      lz = 0;
      while (lz < 32 && ((y << lz) & 32'h8000_0000) == 32'h0) lz++;
      a = sg ? lz - 1 : lz;
    end
  endtask

  task automatic run(input int s, input logic [31:0] x, input logic sg, input int hold, input string tag);
    int a, cyc, lat, exp_lat;
    logic zero;
    logic [31:0] restored, snap_d;
    logic [4:0] snap_a;
    ref_norm(x, sg, a, zero);
    exp_lat = zero ? 1 : (a / step_of(s)) + 2;
    @(negedge clk);
    in_data[s] = x; in_signed[s] = sg; in_valid[s] = 1'b1;
    check({tag, ".rdy_idle"}, 32'(in_ready[s]), 32'd1);
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    cyc = 0;
    while (!out_valid[s] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc + 1;
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, out_data[s], x << a);
    check({tag, ".amt"}, 32'(out_amount[s]), 32'(a));
    check({tag, ".zero"}, 32'(out_zero[s]), 32'(zero));
    check({tag, ".type"}, 32'(out_shift[s].shift_type), 32'(sg ? SHIFT_ASR : SHIFT_SHR));
    check({tag, ".sh_amt"}, 32'(out_shift[s].amount), 32'(a));
    restored = (out_shift[s].shift_type == SHIFT_ASR)
             ? 32'($signed(out_data[s]) >>> out_shift[s].amount)
             : out_data[s] >> out_shift[s].amount;
    check({tag, ".roundtrip"}, restored, x);
    check({tag, ".rdy_done"}, 32'(in_ready[s]), 32'd0);
    snap_d = out_data[s];
    snap_a = out_amount[s];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(out_valid[s]), 32'd1);
      check({tag, ".hold_data"}, out_data[s], snap_d);
      check({tag, ".hold_amt"}, 32'(out_amount[s]), 32'(snap_a));
      check({tag, ".hold_rdy"}, 32'(in_ready[s]), 32'd0);
      in_valid[s] = (i % 2 == 0);
      in_data[s]  = ~x;
    end
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid[s]), 32'd0);
    check({tag, ".post_rdy"}, 32'(in_ready[s]), 32'd1);
    check({tag, ".post_data"}, out_data[s], x << a);
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("%s%0d.rdy", tag, s), 32'(in_ready[s]), 32'd1);
      check($sformatf("%s%0d.valid", tag, s), 32'(out_valid[s]), 32'd0);
      check($sformatf("%s%0d.data", tag, s), out_data[s], 32'h0);
      check($sformatf("%s%0d.amt", tag, s), 32'(out_amount[s]), 32'd0);
      check($sformatf("%s%0d.zero", tag, s), 32'(out_zero[s]), 32'd0);
      check($sformatf("%s%0d.type", tag, s), 32'(out_shift[s].shift_type), 32'(SHIFT_SHR));
    end
  endtask

  initial begin
    logic [31:0] x;
    logic sg;
    int seen_valid;
    for (int s = 0; s < 3; s++) in_data[s] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 32'h0000_0001, 1'b0, 0, "u_one");
    run(1, 32'h8000_0000, 1'b0, 0, "u_top");
    run(1, 32'hFFFF_FFF0, 1'b1, 0, "s_neg");
    run(1, 32'h0000_00FF, 1'b1, 0, "s_pos");
    run(1, 32'h0000_0000, 1'b0, 0, "u_zero");
    run(1, 32'hFFFF_FFFF, 1'b1, 0, "s_ones");
    run(1, 32'h0000_0000, 1'b1, 0, "s_zero");
    run(1, 32'h0001_2345, 1'b0, 5, "bp");
    run(0, 32'h0000_0001, 1'b0, 0, "st1_one");
    run(2, 32'h0000_0001, 1'b0, 0, "st16_one");
    run(2, 32'h0000_8000, 1'b0, 0, "st16_b15");

    // Reset aborts an operation in its third SCAN cycle.
    @(negedge clk);
    in_data[1] = 32'h0000_0001; in_signed[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort.scan_valid", 32'(out_valid[1]), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("abort");
    seen_valid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid != 3'b000) seen_valid++;
    end
    check("abort.no_valid", 32'(seen_valid), 32'd0);

    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 30; n++) begin
        x  = $urandom >> $urandom_range(0, 31);
        sg = 1'($urandom_range(0, 1));
        if (sg && $urandom_range(0, 1) == 1) x = ~x;
        if ($urandom_range(0, 15) == 0) x = sg ? 32'hFFFF_FFFF : 32'h0;
        run(s, x, sg, $urandom_range(0, 2), $sformatf("rnd%0d_%0d", s, n));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
